// File: rtl/histogram_peak_finder_if.sv
// Histogram readout/clear bus between the histogram block and its peak finder.
// The peak finder is the master: it requests readouts and clears, and the
// histogram answers with x/y bin beats and a clear acknowledge.
interface histogram_peak_finder_if;
    logic       readHistogram;
    logic       clearHistogram;
    logic [7:0] xHistogramIn;
    logic [7:0] yHistogramIn;
    logic       xValid;
    logic       yValid;
    logic       histogramCleared;

    modport master (
        output readHistogram, clearHistogram,
        input  xHistogramIn, yHistogramIn, xValid, yValid, histogramCleared
    );

    modport slave (
        input  readHistogram, clearHistogram,
        output xHistogramIn, yHistogramIn, xValid, yValid, histogramCleared
    );
endinterface

// File: rtl/histogram_peak_finder.sv
// Histogram peak finder: requests a histogram readout, scans the x and y
// projection streams for the per-axis peak and the thresholded extent,
// clears the histogram and publishes registered results with a done pulse.
module histogram_peak_finder #(
    parameter int BINS          = 256,
    parameter int CLEAR_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               threshold,
    output logic                     ready,
    output logic                     done,
    output logic                     error,
    histogram_peak_finder_if.master  hist,
    output logic [7:0]               xPeakBin,
    output logic [7:0]               yPeakBin,
    output logic [7:0]               xPeakCount,
    output logic [7:0]               yPeakCount,
    output logic [7:0]               xMin,
    output logic [7:0]               xMax,
    output logic [7:0]               yMin,
    output logic [7:0]               yMax,
    output logic                     boxValid
);
    localparam int          TW      = (CLEAR_TIMEOUT < 2) ? 1 : $clog2(CLEAR_TIMEOUT + 1);
    localparam logic [8:0]  LP_BINS = 9'(BINS);
    localparam logic [TW-1:0] LP_TMO = TW'(CLEAR_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_COLLECT, S_CLEAR, S_WAITCLR, S_DONE
    } state_t;

    state_t        r_state;
    logic          r_ready, r_done, r_error, r_read, r_clear;
    logic [7:0]    r_thr;
    logic [TW-1:0] r_tmo;

    // Per-axis running accumulators, valid while collecting.
    logic [8:0]    r_x_cnt, r_y_cnt;
    logic [7:0]    r_x_max, r_y_max, r_x_idx, r_y_idx;
    logic [7:0]    r_x_min, r_x_lst, r_y_min, r_y_lst;
    logic          r_x_fnd, r_y_fnd;

    // Published results, updated only when leaving WAITCLR.
    logic [7:0]    r_xpb, r_xpc, r_ypb, r_ypc, r_xmin, r_xmax, r_ymin, r_ymax;
    logic          r_box;

    logic          w_x_beat, w_y_beat, w_x_hit, w_y_hit, w_cols_done;

    // A beat only counts while its axis still has bins outstanding.
    assign w_x_beat    = hist.xValid && (r_x_cnt != LP_BINS);
    assign w_y_beat    = hist.yValid && (r_y_cnt != LP_BINS);
    assign w_x_hit     = hist.xHistogramIn > r_thr;
    assign w_y_hit     = hist.yHistogramIn > r_thr;
    assign w_cols_done = (r_x_cnt == LP_BINS) && (r_y_cnt == LP_BINS);

    // Control FSM with accumulation and result publication; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_read  <= 1'b0;
            r_clear <= 1'b0;
            r_thr   <= '0;
            r_tmo   <= '0;
            r_x_cnt <= '0;  r_y_cnt <= '0;
            r_x_max <= '0;  r_y_max <= '0;
            r_x_idx <= '0;  r_y_idx <= '0;
            r_x_min <= '0;  r_y_min <= '0;
            r_x_lst <= '0;  r_y_lst <= '0;
            r_x_fnd <= 1'b0; r_y_fnd <= 1'b0;
            r_xpb   <= '0;  r_xpc   <= '0;
            r_ypb   <= '0;  r_ypc   <= '0;
            r_xmin  <= '0;  r_xmax  <= '0;
            r_ymin  <= '0;  r_ymax  <= '0;
            r_box   <= 1'b0;
        end else begin
            r_read  <= 1'b0;
            r_clear <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_thr   <= threshold;
                        r_error <= 1'b0;
                        r_ready <= 1'b0;
                        r_read  <= 1'b1;
                        r_x_cnt <= '0;  r_y_cnt <= '0;
                        r_x_max <= '0;  r_y_max <= '0;
                        r_x_idx <= '0;  r_y_idx <= '0;
                        r_x_min <= '0;  r_y_min <= '0;
                        r_x_lst <= '0;  r_y_lst <= '0;
                        r_x_fnd <= 1'b0; r_y_fnd <= 1'b0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: r_state <= S_COLLECT;
                S_COLLECT: begin
                    if (w_x_beat) begin
                        r_x_cnt <= r_x_cnt + 9'd1;
                        // strict compare keeps the lowest index on ties
                        if (hist.xHistogramIn > r_x_max) begin
                            r_x_max <= hist.xHistogramIn;
                            r_x_idx <= r_x_cnt[7:0];
                        end
                        if (w_x_hit) begin
                            if (!r_x_fnd) r_x_min <= r_x_cnt[7:0];
                            r_x_lst <= r_x_cnt[7:0];
                            r_x_fnd <= 1'b1;
                        end
                    end
                    if (w_y_beat) begin
                        r_y_cnt <= r_y_cnt + 9'd1;
                        if (hist.yHistogramIn > r_y_max) begin
                            r_y_max <= hist.yHistogramIn;
                            r_y_idx <= r_y_cnt[7:0];
                        end
                        if (w_y_hit) begin
                            if (!r_y_fnd) r_y_min <= r_y_cnt[7:0];
                            r_y_lst <= r_y_cnt[7:0];
                            r_y_fnd <= 1'b1;
                        end
                    end
                    if (w_cols_done) begin
                        r_clear <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_tmo   <= '0;
                    r_state <= S_WAITCLR;
                end
                S_WAITCLR: begin
                    if (hist.histogramCleared || (r_tmo == LP_TMO)) begin
                        r_error <= !hist.histogramCleared;
                        r_done  <= 1'b1;
                        r_xpb   <= r_x_idx;  r_xpc  <= r_x_max;
                        r_ypb   <= r_y_idx;  r_ypc  <= r_y_max;
                        r_xmin  <= r_x_min;  r_xmax <= r_x_lst;
                        r_ymin  <= r_y_min;  r_ymax <= r_y_lst;
                        r_box   <= r_x_fnd && r_y_fnd;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready               = r_ready;
    assign done                = r_done;
    assign error               = r_error;
    assign hist.readHistogram  = r_read;
    assign hist.clearHistogram = r_clear;
    assign xPeakBin            = r_xpb;
    assign xPeakCount          = r_xpc;
    assign yPeakBin            = r_ypb;
    assign yPeakCount          = r_ypc;
    assign xMin                = r_xmin;
    assign xMax                = r_xmax;
    assign yMin                = r_ymin;
    assign yMax                = r_ymax;
    assign boxValid            = r_box;
endmodule

// File: tb/tb_histogram_peak_finder.sv
// Self-checking bench for histogram_peak_finder: a scoreboard queue holds the
// expected result of every started analysis and is compared on each done.
module tb_histogram_peak_finder;
    localparam int BINS = 256;
    localparam int TMO  = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] threshold = 8'd0;
    logic       ready, done, error, boxValid;
    logic [7:0] xPeakBin, yPeakBin, xPeakCount, yPeakCount, xMin, xMax, yMin, yMax;

    histogram_peak_finder_if hif ();

    histogram_peak_finder #(.BINS(BINS), .CLEAR_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .threshold(threshold),
        .ready(ready), .done(done), .error(error), .hist(hif),
        .xPeakBin(xPeakBin), .yPeakBin(yPeakBin),
        .xPeakCount(xPeakCount), .yPeakCount(yPeakCount),
        .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
        .boxValid(boxValid)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] xpb, xpc, ypb, ypc, xmin, xmax, ymin, ymax;
        logic       box, err;
    } res_t;

    res_t       sb[$];
    int         errors = 0, checks = 0;
    int         n_done = 0, n_read = 0, n_clear = 0;
    int         cyc = 0, clr_cyc = 0, done_cyc = 0;
    logic [7:0] xb[BINS], yb[BINS];
    bit         ack_en = 1'b1;
    int         ack_hold = 0;

    // Expected result: find the maximum first, then its lowest index; extent by
    // scanning from each end for the first bin above threshold.
    function automatic res_t model(input logic [7:0] thr, input logic err);
        res_t r;
        int   mx;
        bit   xf, yf;
        r = '0; xf = 0; yf = 0;
        mx = 0;
        for (int i = 0; i < BINS; i++) if (int'(xb[i]) > mx) mx = int'(xb[i]);
        r.xpc = 8'(mx);
        for (int i = BINS - 1; i >= 0; i--) if (int'(xb[i]) == mx) r.xpb = 8'(i);
        for (int i = BINS - 1; i >= 0; i--) if (xb[i] > thr) begin r.xmin = 8'(i); xf = 1; end
        for (int i = 0; i < BINS; i++) if (xb[i] > thr) r.xmax = 8'(i);
        mx = 0;
        for (int i = 0; i < BINS; i++) if (int'(yb[i]) > mx) mx = int'(yb[i]);
        r.ypc = 8'(mx);
        for (int i = BINS - 1; i >= 0; i--) if (int'(yb[i]) == mx) r.ypb = 8'(i);
        for (int i = BINS - 1; i >= 0; i--) if (yb[i] > thr) begin r.ymin = 8'(i); yf = 1; end
        for (int i = 0; i < BINS; i++) if (yb[i] > thr) r.ymax = 8'(i);
        r.box = xf && yf;
        r.err = err;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor plus strobe counters, sampled on the falling edge.
    initial forever begin
        res_t o, e;
        @(negedge clk);
        if (reset) begin
            if (hif.readHistogram) n_read++;
            if (hif.clearHistogram) begin n_clear++; clr_cyc = cyc; end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done=1 with empty scoreboard, required no done");
                end else begin
                    e = sb.pop_front();
                    o = {xPeakBin, xPeakCount, yPeakBin, yPeakCount, xMin, xMax, yMin, yMax, boxValid, error};
                    if (o !== e) begin
                        errors++;
                        $display("FAIL results: got %h required %h (xpb xpc ypb ypc xmin xmax ymin ymax box err)", o, e);
                    end
                end
            end
        end
    end

    // Histogram clear acknowledge: held two cycles after seeing the clear request.
    initial forever begin
        @(negedge clk);
        if (ack_hold > 0) begin
            ack_hold--;
            if (ack_hold == 0) hif.histogramCleared = 1'b0;
        end
        if (hif.clearHistogram && ack_en) begin
            hif.histogramCleared = 1'b1;
            ack_hold = 2;
        end
    end

    task automatic clear_data();
        for (int i = 0; i < BINS; i++) begin xb[i] = 8'd0; yb[i] = 8'd0; end
    endtask

    // mode 0: all x then all y; 1: both every cycle; 2: random gaps interleaved.
    task automatic stream(input int mode, input int xn, input bit start_mid);
        int xi = 0, yi = 0, guard = 0;
        bit xgo, ygo, mid_sent = 0;
        while ((xi < xn || yi < BINS) && guard < 5000) begin
            hif.xValid = 1'b0;
            hif.yValid = 1'b0;
            start = 1'b0;
            case (mode)
                0: begin xgo = xi < xn; ygo = !xgo && (yi < BINS); end
                1: begin xgo = xi < xn; ygo = yi < BINS; end
                default: begin
                    xgo = (xi < xn) && ($urandom_range(0, 2) != 0);
                    ygo = (yi < BINS) && ($urandom_range(0, 2) != 0);
                end
            endcase
            if (xgo) begin
                hif.xValid = 1'b1;
                hif.xHistogramIn = (xi < BINS) ? xb[xi] : 8'hFF;
                xi++;
            end
            if (ygo) begin
                hif.yValid = 1'b1;
                hif.yHistogramIn = yb[yi];
                yi++;
            end
            if (start_mid && !mid_sent && xi == 100) begin start = 1'b1; mid_sent = 1; end
            @(negedge clk);
            guard++;
        end
        hif.xValid = 1'b0;
        hif.yValid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run(input logic [7:0] thr, input int mode, input int xn,
                       input bit start_mid, input bit exp_err);
        int g = 0;
        while (!ready && g < 100) begin @(negedge clk); g++; end
        threshold = thr;
        start = 1'b1;
        sb.push_back(model(thr, exp_err));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hif.readHistogram !== 1'b1) begin
            errors++;
            $display("FAIL read_request: got readHistogram=%b required 1", hif.readHistogram);
        end
        @(negedge clk);
        stream(mode, xn, start_mid);
        g = 0;
        while (!done && g < 200) begin @(negedge clk); g++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got done=%b required 1 within 200 cycles", done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready, done, error, boxValid, hif.readHistogram, hif.clearHistogram} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/done/err/box/rd/clr=%b required 100000",
                     {ready, done, error, boxValid, hif.readHistogram, hif.clearHistogram});
        end
        checks++;
        if ({xPeakBin, xPeakCount, yPeakBin, yPeakCount, xMin, xMax, yMin, yMax} !== 64'd0) begin
            errors++;
            $display("FAIL reset_results: got %h required 0",
                     {xPeakBin, xPeakCount, yPeakBin, yPeakCount, xMin, xMax, yMin, yMax});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", ready);
        end
    endtask

    task automatic test_basic();
        int d0 = n_done, r0 = n_read, c0 = n_clear;
        clear_data();
        xb[10] = 8'd5; xb[200] = 8'd9; yb[37] = 8'd200;
        run(8'd4, 1, BINS, 0, 0);
        checks++;
        if ({xPeakBin, xPeakCount, xMin, xMax, yPeakBin, yPeakCount, yMin, yMax, boxValid} !==
            {8'd200, 8'd9, 8'd10, 8'd200, 8'd37, 8'd200, 8'd37, 8'd37, 1'b1}) begin
            errors++;
            $display("FAIL basic_fixed: got %h required %h",
                     {xPeakBin, xPeakCount, xMin, xMax, yPeakBin, yPeakCount, yMin, yMax, boxValid},
                     {8'd200, 8'd9, 8'd10, 8'd200, 8'd37, 8'd200, 8'd37, 8'd37, 1'b1});
        end
        checks++;
        if ((n_done - d0) != 1 || (n_read - r0) != 1 || (n_clear - c0) != 1) begin
            errors++;
            $display("FAIL basic_strobes: got done/read/clear=%0d/%0d/%0d required 1/1/1",
                     n_done - d0, n_read - r0, n_clear - c0);
        end
    endtask

    task automatic test_tie_zero();
        clear_data();
        xb[3] = 8'd50; xb[7] = 8'd50;
        run(8'd0, 0, BINS, 0, 0);
        checks++;
        if ({xPeakBin, yPeakCount, yMin, yMax, boxValid} !== {8'd3, 8'd0, 8'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL tie_zero: got xpb=%0d ypc=%0d ymin=%0d ymax=%0d box=%b required 3 0 0 0 0",
                     xPeakBin, yPeakCount, yMin, yMax, boxValid);
        end
    endtask

    task automatic test_ordering();
        res_t a;
        int r0, c0;
        for (int i = 0; i < BINS; i++) begin
            xb[i] = 8'($urandom_range(0, 200));
            yb[i] = 8'($urandom_range(0, 200));
        end
        for (int m = 0; m < 3; m++) begin
            r0 = n_read; c0 = n_clear;
            run(8'd150, m, BINS, 0, 0);
            if (m == 0) a = {xPeakBin, xPeakCount, yPeakBin, yPeakCount, xMin, xMax, yMin, yMax, boxValid, error};
            checks++;
            if ({xPeakBin, xPeakCount, yPeakBin, yPeakCount, xMin, xMax, yMin, yMax, boxValid, error} !== a) begin
                errors++;
                $display("FAIL order_mode%0d: got %h required %h", m,
                         {xPeakBin, xPeakCount, yPeakBin, yPeakCount, xMin, xMax, yMin, yMax, boxValid, error}, a);
            end
            checks++;
            if ((n_read - r0) != 1 || (n_clear - c0) != 1) begin
                errors++;
                $display("FAIL order_strobes%0d: got read/clear=%0d/%0d required 1/1", m, n_read - r0, n_clear - c0);
            end
        end
    endtask

    task automatic test_timeout();
        clear_data();
        xb[5] = 8'd20; yb[6] = 8'd30;
        ack_en = 1'b0;
        run(8'd10, 1, BINS, 0, 1);
        checks++;
        if ((done_cyc - clr_cyc) < 16 || (done_cyc - clr_cyc) > 17) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles clear-to-done required 16..17", done_cyc - clr_cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL error_hold: got error=%b required 1", error);
        end
        ack_en = 1'b1;
        run(8'd10, 1, BINS, 0, 0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: got error=%b required 0", error);
        end
    endtask

    task automatic test_extra_beats();
        int r0;
        clear_data();
        xb[0] = 8'd3; xb[255] = 8'd7; xb[128] = 8'd6; yb[1] = 8'd9; yb[254] = 8'd2;
        hif.xValid = 1'b1; hif.yValid = 1'b1;
        hif.xHistogramIn = 8'hFF; hif.yHistogramIn = 8'hFF;
        repeat (5) @(negedge clk);
        hif.xValid = 1'b0; hif.yValid = 1'b0;
        r0 = n_read;
        run(8'd1, 0, BINS + 5, 1, 0);
        checks++;
        if ((n_read - r0) != 1) begin
            errors++;
            $display("FAIL start_in_collect: got %0d read requests required 1", n_read - r0);
        end
    endtask

    task automatic test_reset_mid();
        int d0, g = 0;
        while (!ready && g < 100) begin @(negedge clk); g++; end
        clear_data();
        xb[40] = 8'd77; yb[90] = 8'd66;
        threshold = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            hif.xValid = 1'b1; hif.xHistogramIn = 8'd99;
            @(negedge clk);
        end
        hif.xValid = 1'b0;
        d0 = n_done;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({ready, done, error, boxValid, hif.readHistogram, hif.clearHistogram} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got rdy/done/err/box/rd/clr=%b required 100000",
                     {ready, done, error, boxValid, hif.readHistogram, hif.clearHistogram});
        end
        checks++;
        if ({xPeakBin, xPeakCount, yPeakBin, yPeakCount, xMin, xMax, yMin, yMax} !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_results: got %h required 0",
                     {xPeakBin, xPeakCount, yPeakBin, yPeakCount, xMin, xMax, yMin, yMax});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (n_done != d0) begin
            errors++;
            $display("FAIL reset_mid_done: got %0d done pulses required 0", n_done - d0);
        end
        run(8'd5, 2, BINS, 0, 0);
    endtask

    initial begin
        hif.xValid = 1'b0; hif.yValid = 1'b0;
        hif.xHistogramIn = 8'd0; hif.yHistogramIn = 8'd0;
        hif.histogramCleared = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie_zero();
        test_ordering();
        test_timeout();
        test_extra_beats();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending results required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/histogram_peak_finder.md
Name: histogram_peak_finder

Overview:
- Downstream consumer of the histogram stage: requests a histogram readout, streams x and y projection bins, and extracts per-axis peak bin/count and the thresholded extent (bounding box).
- On completion it clears the histogram and pulses done, leaving registered results for the tracking/readout logic.
- Sits between the histogram computation block and the top-level controller.

Parameters:
- BINS, 256, number of bins per axis streamed by the histogram (2..256); bin index is 8 bits.
- CLEAR_TIMEOUT, 1023, maximum cycles to wait for histogramCleared before flagging an error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to analyse the current histogram; sampled only in IDLE.
- threshold  input  8  extent threshold; sampled at start.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse when results update.
- error  output  1  high from DONE until next start if clear timed out.
- readHistogram  output  1  one-cycle request to histogram.
- clearHistogram  output  1  one-cycle clear request to histogram.
- xHistogramIn  input  8  x bin count, valid with xValid.
- yHistogramIn  input  8  y bin count, valid with yValid.
- xValid  input  1  x bin beat strobe.
- yValid  input  1  y bin beat strobe.
- histogramCleared  input  1  clear acknowledge (level or pulse).
- xPeakBin, yPeakBin  output  8  index of first bin holding the maximum count.
- xPeakCount, yPeakCount  output  8  that maximum count.
- xMin, xMax, yMin, yMax  output  8  first/last bin with count > threshold.
- boxValid  output  1  at least one bin above threshold on both axes.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0 except ready=1; internal accumulators cleared. Reset mid-operation aborts, drops readHistogram/clearHistogram immediately, with no done pulse.
- FSM: IDLE -> REQ -> COLLECT -> CLEAR -> WAITCLR -> DONE -> IDLE.
- IDLE: ready=1. start=1 latches threshold, clears accumulators, moves to REQ. xValid/yValid beats in IDLE are ignored.
- REQ: readHistogram=1 for exactly one cycle, then COLLECT.
- COLLECT: independent 9-bit beat counters xCnt/yCnt. Each xValid beat is bin index xCnt, and likewise for y. The x and y streams may be concurrent, interleaved or sequential. Beats after a counter reaches BINS are ignored. Leave when xCnt==BINS and yCnt==BINS; there is no timeout here.
- Peak per axis: update when count > running max (strict), so ties keep the lowest index. Running max starts at 0 with index 0, so an all-zero axis gives PeakBin=0, PeakCount=0.
- Extent per axis: on count > threshold, set found; Min is set only on the first hit and Max is overwritten on every hit. If there is no hit: Min=Max=0, found=0.
- CLEAR: clearHistogram=1 for one cycle, then WAITCLR.
- WAITCLR: exit on histogramCleared=1 (an acknowledge in the same cycle as entry counts), or when the timeout counter reaches CLEAR_TIMEOUT, which sets the error flag.
- DONE: for one cycle, register all results, boxValid=xFound&yFound, error, and done=1; then IDLE. Results hold until the next DONE.
- start outside IDLE is ignored. start in the same cycle as DONE is ignored; ready rises the following cycle.
- Minimum latency from start to done: 3 + max(beat-completion cycles) + 1 (WAITCLR) + 1.

Test Plan:
- x bins all 0 except bin 10=5 and bin 200=9; y bin 37=200; threshold=4 -> xPeakBin=200, xPeakCount=9, xMin=10, xMax=200, yPeakBin=yMin=yMax=37, yPeakCount=200, boxValid=1, one done pulse.
- Tie: x bins 3 and 7 both =50 -> xPeakBin=3. All-zero y with threshold=0 -> yMin=yMax=0, boxValid=0, yPeakCount=0.
- Stream ordering: full x stream then full y stream, versus interleaved with random gaps -> identical results; readHistogram and clearHistogram each high exactly one cycle per start.
- histogramCleared never asserted, CLEAR_TIMEOUT=15 -> done pulses 16–17 cycles after CLEAR, error=1; next run with acknowledge -> error=0.
- Extra beats: BINS+5 x beats, plus stray beats in IDLE -> results reflect only the first BINS beats; start during COLLECT is ignored with no second readHistogram.
- Assert reset mid-COLLECT -> all outputs 0 and ready=1 asynchronously; a subsequent full run is correct.
